// File: rtl/srisc_pkg.sv
// Shared encodings for the Simple RISC execution core.
package srisc_pkg;

    // Instruction opcodes in IR[15:13]
    typedef enum logic [2:0] {
        OpcB    = 3'b001,
        OpcLdr  = 3'b011,
        OpcStr  = 3'b100,
        OpcAlu  = 3'b101,
        OpcMov  = 3'b110,
        OpcHalt = 3'b111
    } opcode_e;

    // ALU operation in IR[12:11]
    typedef enum logic [1:0] {
        AluAdd = 2'b00,
        AluSub = 2'b01,
        AluAnd = 2'b10,
        AluNot = 2'b11
    } alu_op_e;

    // Shift applied to B in IR[4:3]
    typedef enum logic [1:0] {
        ShPass = 2'b00,
        ShLsl  = 2'b01,
        ShLsr  = 2'b10,
        ShAsr  = 2'b11
    } shift_e;

    // One-hot write-back source select
    typedef enum logic [3:0] {
        VselC     = 4'b0001,
        VselPc    = 4'b0010,
        VselImm8  = 4'b0100,
        VselMdata = 4'b1000
    } vsel_e;

    // Bit positions of the one-hot register-index select
    localparam int unsigned NselRmBit = 0;
    localparam int unsigned NselRdBit = 1;
    localparam int unsigned NselRnBit = 2;

endpackage

// File: rtl/srisc_regfile.sv
// 8-entry register file: one write port, one combinational read port.
module srisc_regfile #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         write,
    input  logic [2:0]   index,
    input  logic [W-1:0] data_in,
    output logic [W-1:0] data_out
);

    logic [W-1:0] regs_q [8];
    logic [W-1:0] regs_d [8];

    // Next-state: only the indexed entry changes on a write
    always_comb begin
        regs_d = regs_q;
        if (write) begin
            regs_d[index] = data_in;
        end
    end

    // Register storage with asynchronous clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign data_out = regs_q[index];

endmodule

// File: rtl/srisc_exec_core.sv
// Simple RISC execution core: IR, decoder, register file, shifter, ALU and status.
module srisc_exec_core
    import srisc_pkg::*;
#(
    parameter int unsigned W   = 16,
    parameter int unsigned PCW = 9
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [W-1:0]   read_data,
    input  logic           load_ir,
    input  logic [2:0]     nsel,
    input  logic [3:0]     vsel,
    input  logic           write,
    input  logic           loada,
    input  logic           loadb,
    input  logic           asel,
    input  logic           bsel,
    input  logic           loadc,
    input  logic           loads,
    input  logic [W-1:0]   mdata,
    input  logic [PCW-1:0] pc,
    output logic [2:0]     opcode,
    output logic [1:0]     op,
    output logic [2:0]     cond,
    output logic [W-1:0]   sximm8,
    output logic [2:0]     status,
    output logic [W-1:0]   datapath_out
);

    logic [W-1:0] ir_q, ir_d;
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic [W-1:0] c_q, c_d;
    logic [2:0]   status_q, status_d;

    logic [2:0]   rn, rd, rm, index;
    logic [1:0]   shift;
    logic [W-1:0] sximm5, rf_wdata, rf_rdata;
    logic [W-1:0] b_shifted, ain, bin, alu_res;
    logic         alu_v;

    // Decoder: all fields come straight from IR
    always_comb begin
        opcode = ir_q[15:13];
        op     = ir_q[12:11];
        cond   = ir_q[10:8];
        rn     = ir_q[10:8];
        rd     = ir_q[7:5];
        shift  = ir_q[4:3];
        rm     = ir_q[2:0];
        sximm8 = {{(W-8){ir_q[7]}}, ir_q[7:0]};
        sximm5 = {{(W-5){ir_q[4]}}, ir_q[4:0]};
        index  = ({3{nsel[NselRmBit]}} & rm)
               | ({3{nsel[NselRdBit]}} & rd)
               | ({3{nsel[NselRnBit]}} & rn);
    end

    // Write-back mux; an invalid (non-one-hot) select writes zero
    always_comb begin
        rf_wdata = '0;
        case (vsel)
            VselC:     rf_wdata = c_q;
            VselPc:    rf_wdata = {{(W-PCW){1'b0}}, pc};
            VselImm8:  rf_wdata = sximm8;
            VselMdata: rf_wdata = mdata;
            default:   rf_wdata = '0;
        endcase
    end

    srisc_regfile #(
        .W (W)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .write    (write),
        .index    (index),
        .data_in  (rf_wdata),
        .data_out (rf_rdata)
    );

    // Shifter, operand select and ALU with flags
    always_comb begin
        unique case (shift_e'(shift))
            ShPass: b_shifted = b_q;
            ShLsl:  b_shifted = {b_q[W-2:0], 1'b0};
            ShLsr:  b_shifted = {1'b0, b_q[W-1:1]};
            ShAsr:  b_shifted = {b_q[W-1], b_q[W-1:1]};
            default: b_shifted = b_q;
        endcase
        ain = asel ? '0 : a_q;
        bin = bsel ? sximm5 : b_shifted;
        alu_res = '0;
        alu_v   = 1'b0;
        unique case (alu_op_e'(op))
            AluAdd: begin
                alu_res = ain + bin;
                alu_v   = (ain[W-1] == bin[W-1]) && (alu_res[W-1] != ain[W-1]);
            end
            AluSub: begin
                alu_res = ain - bin;
                alu_v   = (ain[W-1] != bin[W-1]) && (alu_res[W-1] != ain[W-1]);
            end
            AluAnd: alu_res = ain & bin;
            AluNot: alu_res = ~bin;
            default: alu_res = '0;
        endcase
    end

    // Next-state for IR and the pipeline/status registers
    always_comb begin
        ir_d     = load_ir ? read_data : ir_q;
        a_d      = loada ? rf_rdata : a_q;
        b_d      = loadb ? rf_rdata : b_q;
        c_d      = loadc ? alu_res : c_q;
        status_d = loads ? {alu_v, alu_res[W-1], (alu_res == '0)} : status_q;
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            status_q <= '0;
        end else begin
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            status_q <= status_d;
        end
    end

    assign status       = status_q;
    assign datapath_out = c_q;

endmodule

// File: tb/tb_srisc_exec_core.sv
// Directed and randomized checks of srisc_exec_core against a behavioural model.
module tb_srisc_exec_core;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] read_data;
    logic        load_ir;
    logic [2:0]  nsel;
    logic [3:0]  vsel;
    logic        write, loada, loadb, asel, bsel, loadc, loads;
    logic [15:0] mdata;
    logic [8:0]  pc;
    logic [2:0]  opcode, cond, status;
    logic [1:0]  op;
    logic [15:0] sximm8, datapath_out;

    int vectors = 0;
    int miscompares = 0;

    // Model state: architectural registers only
    logic [15:0] mdl_r [8];

    always #5 clk = ~clk;

    srisc_exec_core dut (
        .clk          (clk),
        .reset        (reset),
        .read_data    (read_data),
        .load_ir      (load_ir),
        .nsel         (nsel),
        .vsel         (vsel),
        .write        (write),
        .loada        (loada),
        .loadb        (loadb),
        .asel         (asel),
        .bsel         (bsel),
        .loadc        (loadc),
        .loads        (loads),
        .mdata        (mdata),
        .pc           (pc),
        .opcode       (opcode),
        .op           (op),
        .cond         (cond),
        .sximm8       (sximm8),
        .status       (status),
        .datapath_out (datapath_out)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        load_ir = 0; nsel = 0; vsel = 0; write = 0; loada = 0; loadb = 0;
        asel = 0; bsel = 0; loadc = 0; loads = 0;
    endtask

    task automatic set_ir(input logic [15:0] v);
        read_data = v; load_ir = 1; tick(); load_ir = 0;
    endtask

    // Write-back into the register picked by nsel from the current IR
    task automatic wb(input logic [2:0] ns, input logic [3:0] vs);
        nsel = ns; vsel = vs; write = 1; tick(); idle();
    endtask

    // Observe R[x] through the datapath: C = 0 + R[x]
    task automatic read_reg(input int x, input logic [15:0] exp, input string tag);
        logic [15:0] ir;
        ir = 16'hA000;
        ir[2:0] = x[2:0];
        set_ir(ir);
        nsel = 3'b001; loadb = 1; tick(); idle();
        asel = 1; loadc = 1; tick(); idle();
        chk(tag, datapath_out, exp);
    endtask

    function automatic int sval(input logic [15:0] x);
        return x[15] ? int'(x) - 65536 : int'(x);
    endfunction

    // Reference ALU from the arithmetic definition
    task automatic model_alu(input logic [15:0] ain, input logic [15:0] bin, input logic [1:0] aop,
                             output logic [15:0] res, output logic [2:0] st);
        int s;
        logic v;
        v = 1'b0;
        case (aop)
            2'd0: begin s = sval(ain) + sval(bin); v = (s > 32767) || (s < -32768); end
            2'd1: begin s = sval(ain) - sval(bin); v = (s > 32767) || (s < -32768); end
            2'd2: s = int'(ain & bin);
            default: s = int'(~bin);
        endcase
        res = s[15:0];
        st = {v, res[15], res == 16'h0};
    endtask

    function automatic logic [15:0] model_shift(input logic [15:0] b, input logic [1:0] sh);
        case (sh)
            2'd0: return b;
            2'd1: return b * 2;
            2'd2: return b / 2;
            default: return (b / 2) + (b[15] ? 16'h8000 : 16'h0);
        endcase
    endfunction

    initial begin
        logic [15:0] instr, res, ain, bin, old3, v16;
        logic [2:0]  st, rn, rd, rm;
        logic [1:0]  aop, sh;
        logic        as_r, bs_r;

        idle();
        read_data = 0; mdata = 0; pc = 0;
        reset = 0;
        for (int i = 0; i < 8; i++) mdl_r[i] = 16'h0;
        tick(); tick();
        chk("rst_opcode", {13'h0, opcode}, 16'h0);
        chk("rst_op", {14'h0, op}, 16'h0);
        chk("rst_cond", {13'h0, cond}, 16'h0);
        chk("rst_sximm8", sximm8, 16'h0);
        chk("rst_status", {13'h0, status}, 16'h0);
        chk("rst_dpout", datapath_out, 16'h0);
        reset = 1;
        tick();

        // MOV R0,#5
        set_ir(16'hD005);
        chk("mov_opcode", {13'h0, opcode}, 16'h6);
        chk("mov_op", {14'h0, op}, 16'h2);
        chk("mov_sximm8", sximm8, 16'h5);
        wb(3'b100, 4'b0100);
        read_reg(0, 16'h5, "mov_r0");

        // MOV R1,#7 then ADD R2,R1,R0,LSL#1
        set_ir(16'hD107);
        wb(3'b100, 4'b0100);
        set_ir(16'hA148);
        nsel = 3'b100; loada = 1; tick(); idle();
        nsel = 3'b001; loadb = 1; tick(); idle();
        loadc = 1; tick(); idle();
        chk("add_c", datapath_out, 16'h0011);
        wb(3'b010, 4'b0001);
        read_reg(2, 16'h0011, "add_r2");

        // CMP R0,R1 and CMP R0,R0
        set_ir(16'hA801);
        nsel = 3'b100; loada = 1; tick(); idle();
        nsel = 3'b001; loadb = 1; tick(); idle();
        loads = 1; tick(); idle();
        chk("cmp_lt", {13'h0, status}, 16'h0002);
        set_ir(16'hA800);
        nsel = 3'b001; loadb = 1; tick(); idle();
        loads = 1; tick(); idle();
        chk("cmp_eq", {13'h0, status}, 16'h0001);

        // 7FFF + imm5 1 overflows
        set_ir(16'h6000);
        mdata = 16'h7FFF;
        wb(3'b010, 4'b1000);
        set_ir(16'hA001);
        nsel = 3'b100; loada = 1; tick(); idle();
        bsel = 1; loadc = 1; loads = 1; tick(); idle();
        chk("ovf_c", datapath_out, 16'h8000);
        chk("ovf_status", {13'h0, status}, 16'h0006);

        // Reset pulse in the middle of a loadc cycle
        loadc = 1; loads = 1; asel = 1; bsel = 1;
        #2 reset = 0;
        #1;
        chk("rstmid_c", datapath_out, 16'h0);
        chk("rstmid_status", {13'h0, status}, 16'h0);
        chk("rstmid_opcode", {13'h0, opcode}, 16'h0);
        idle();
        #1 reset = 1;
        for (int i = 0; i < 8; i++) mdl_r[i] = 16'h0;
        tick();
        set_ir(16'hE000);
        chk("halt_opcode", {13'h0, opcode}, 16'h7);
        chk("halt_dpout", datapath_out, 16'h0);
        read_reg(0, 16'h0, "rstmid_r0");

        // LDR write-back, pc write-back, invalid vsel
        set_ir(16'h6020);
        mdata = 16'hBEEF;
        wb(3'b010, 4'b1000);
        mdl_r[1] = 16'hBEEF;
        read_reg(1, 16'hBEEF, "ldr_r1");
        set_ir(16'h6080);
        pc = 9'h1AB;
        wb(3'b010, 4'b0010);
        mdl_r[4] = 16'h01AB;
        read_reg(4, 16'h01AB, "pc_r4");
        set_ir(16'h6020);
        wb(3'b010, 4'b0011);
        mdl_r[1] = 16'h0;
        read_reg(1, 16'h0, "badvsel_r1");

        // Same-edge write and read of R3: A gets the old value
        set_ir(16'h6060);
        mdata = 16'h1234;
        wb(3'b010, 4'b1000);
        old3 = 16'h1234;
        set_ir(16'hA060);
        mdata = 16'h5678;
        nsel = 3'b010; vsel = 4'b1000; write = 1; loada = 1; tick(); idle();
        mdl_r[3] = 16'h5678;
        set_ir(16'hA060);
        bsel = 1; loadc = 1; tick(); idle();
        chk("rw_old", datapath_out, old3);
        read_reg(3, 16'h5678, "rw_new");

        // Seed every register with random data
        for (int i = 0; i < 8; i++) begin
            instr = 16'h6000;
            instr[7:5] = i[2:0];
            set_ir(instr);
            v16 = 16'($urandom);
            mdata = v16;
            wb(3'b010, 4'b1000);
            mdl_r[i] = v16;
        end

        // Random ALU instructions with write-back to Rd
        for (int n = 0; n < 40; n++) begin
            rn = 3'($urandom); rd = 3'($urandom); rm = 3'($urandom);
            aop = 2'($urandom); sh = 2'($urandom);
            as_r = 1'($urandom); bs_r = 1'($urandom);
            instr = {3'b101, aop, rn, rd, sh, rm};
            set_ir(instr);
            nsel = 3'b100; loada = 1; tick(); idle();
            nsel = 3'b001; loadb = 1; tick(); idle();
            asel = as_r; bsel = bs_r; loadc = 1; loads = 1; tick(); idle();
            ain = as_r ? 16'h0 : mdl_r[rn];
            bin = bs_r ? {{11{instr[4]}}, instr[4:0]} : model_shift(mdl_r[rm], sh);
            model_alu(ain, bin, aop, res, st);
            chk($sformatf("rnd%0d_c", n), datapath_out, res);
            chk($sformatf("rnd%0d_st", n), {13'h0, status}, {13'h0, st});
            wb(3'b010, 4'b0001);
            mdl_r[rd] = res;
            if (n % 4 == 3) begin
                rm = 3'($urandom);
                read_reg(int'(rm), mdl_r[rm], $sformatf("rnd%0d_reg", n));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
